// File: rtl/snake_game_core.sv
// snake_game_core
//   Parametrised snake engine. Holds the head, apple and tail-segment storage,
//   advances the snake once every TICK_DIV clocks, handles growth, walls or
//   wrap-around and game-over. Sits between the joystick decoder (dir_in) and
//   the VGA renderer, which walks the body through the tail read port.
//
// Optional feature: define SNAKE_SELF_COLLIDE_EN to end the game when the head
//   steps onto its own body. Without the macro no body comparators exist and
//   the snake may overlap itself.
//
// Ports
//   clk, rst_n        game clock, asynchronous active-low reset
//   start             1-cycle start/restart pulse (honoured in IDLE/GAME_OVER)
//   dir_in, dir_valid requested direction (00 up, 01 right, 10 down, 11 left)
//   head_x, head_y    current head cell
//   apple_x, apple_y  current apple cell
//   num_tails         number of live tail segments
//   tail_rd_idx       body segment to read, 0 = segment nearest the head
//   tail_rd_x/_y/_vld combinational segment read, vld = idx < num_tails
//   tick              high during each step cycle
//   game_over         high in GAME_OVER
//   state             00 IDLE, 01 RUN, 10 APPLE, 11 GAME_OVER
module snake_game_core #(
  parameter int          GRID_W    = 32,
  parameter int          GRID_H    = 24,
  parameter int          X_W       = 5,
  parameter int          Y_W       = 5,
  parameter int          MAX_TAILS = 64,
  parameter int          NT_W      = 7,
  parameter int          TICK_DIV  = 12_500_000,
  parameter int          WRAP_MODE = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [1:0]                   dir_in,
  input  logic                         dir_valid,
  output logic [X_W-1:0]               head_x,
  output logic [Y_W-1:0]               head_y,
  output logic [X_W-1:0]               apple_x,
  output logic [Y_W-1:0]               apple_y,
  output logic [NT_W-1:0]              num_tails,
  input  logic [$clog2(MAX_TAILS)-1:0] tail_rd_idx,
  output logic [X_W-1:0]               tail_rd_x,
  output logic [Y_W-1:0]               tail_rd_y,
  output logic                         tail_rd_vld,
  output logic                         tick,
  output logic                         game_over,
  output logic [1:0]                   state
);

  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    APPLE     = 2'b10,
    GAME_OVER = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [X_W-1:0]  headX_q, headX_d, appleX_q, appleX_d;
  logic [Y_W-1:0]  headY_q, headY_d, appleY_q, appleY_d;
  logic [NT_W-1:0] numTails_q, numTails_d;
  logic [1:0]      dir_q, dir_d, pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [X_W-1:0]  tailX_q [MAX_TAILS];
  logic [Y_W-1:0]  tailY_q [MAX_TAILS];

  logic            stepNow, tailShift, dirAccept;
  logic [X_W-1:0]  nextX, candX;
  logic [Y_W-1:0]  nextY, candY;
  logic            offGrid, wallHit, eat, selfHit, candOk;

  assign stepNow = (state_q == RUN) && (cnt_q == CNT_W'(TICK_DIV - 1));

  // A reversal is judged against the direction currently being travelled,
  // so the snake can never fold back onto its own neck.
  assign dirAccept = dir_valid && (dir_in != (dir_q ^ 2'b10));

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign candX  = lfsr_q[X_W-1:0];
  assign candY  = lfsr_q[X_W+Y_W-1:X_W];
  assign candOk = ((X_W+1)'(candX) < (X_W+1)'(GRID_W)) &&
                  ((Y_W+1)'(candY) < (Y_W+1)'(GRID_H));

  // The step uses the pending direction, which becomes the travelled one at
  // the same edge. offGrid flags a move across an edge; the wrapped cell is
  // produced regardless and only used when wrapping is enabled.
  always_comb begin
    nextX   = headX_q;
    nextY   = headY_q;
    offGrid = 1'b0;
    unique case (pend_q)
      DIR_UP: begin
        offGrid = (headY_q == '0);
        nextY   = offGrid ? Y_W'(GRID_H - 1) : headY_q - Y_W'(1);
      end
      DIR_RIGHT: begin
        offGrid = (headX_q == X_W'(GRID_W - 1));
        nextX   = offGrid ? '0 : headX_q + X_W'(1);
      end
      DIR_DOWN: begin
        offGrid = (headY_q == Y_W'(GRID_H - 1));
        nextY   = offGrid ? '0 : headY_q + Y_W'(1);
      end
      DIR_LEFT: begin
        offGrid = (headX_q == '0);
        nextX   = offGrid ? X_W'(GRID_W - 1) : headX_q - X_W'(1);
      end
    endcase
  end

  assign wallHit = offGrid && (WRAP_MODE == 0);
  assign eat     = (nextX == appleX_q) && (nextY == appleY_q);

`ifdef SNAKE_SELF_COLLIDE_EN
  // The last live segment moves out of the way on a plain step, so it only
  // counts as an obstacle when the snake is growing this step.
  always_comb begin
    selfHit = 1'b0;
    for (int i = 0; i < MAX_TAILS; i++) begin
      if ((NT_W'(i) < numTails_q) &&
          (eat || (NT_W'(i) != numTails_q - NT_W'(1))) &&
          (tailX_q[i] == nextX) && (tailY_q[i] == nextY)) begin
        selfHit = 1'b1;
      end
    end
  end
`else
  assign selfHit = 1'b0;
`endif

  // Game sequencing: start, apple placement, stepping and game-over.
  always_comb begin
    state_d    = state_q;
    headX_d    = headX_q;
    headY_d    = headY_q;
    appleX_d   = appleX_q;
    appleY_d   = appleY_q;
    numTails_d = numTails_q;
    dir_d      = dir_q;
    pend_d     = dirAccept ? dir_in : pend_q;
    cnt_d      = cnt_q;
    tailShift  = 1'b0;
    unique case (state_q)
      IDLE, GAME_OVER: begin
        if (start) begin
          headX_d    = X_W'(GRID_W / 2);
          headY_d    = Y_W'(GRID_H / 2);
          dir_d      = DIR_RIGHT;
          pend_d     = DIR_RIGHT;
          numTails_d = '0;
          cnt_d      = '0;
          state_d    = APPLE;
        end
      end
      APPLE: begin
        cnt_d = '0;
        if (candOk) begin
          appleX_d = candX;
          appleY_d = candY;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (stepNow) begin
          cnt_d = '0;
          dir_d = pend_q;
          if (wallHit || selfHit) begin
            state_d = GAME_OVER;
          end else begin
            tailShift = 1'b1;
            headX_d   = nextX;
            headY_d   = nextY;
            if (eat) begin
              if (numTails_q != NT_W'(MAX_TAILS)) begin
                numTails_d = numTails_q + NT_W'(1);
              end
              state_d = APPLE;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Core game registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      headX_q    <= X_W'(GRID_W / 2);
      headY_q    <= Y_W'(GRID_H / 2);
      appleX_q   <= '0;
      appleY_q   <= '0;
      numTails_q <= '0;
      dir_q      <= DIR_RIGHT;
      pend_q     <= DIR_RIGHT;
      cnt_q      <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      headX_q    <= headX_d;
      headY_q    <= headY_d;
      appleX_q   <= appleX_d;
      appleY_q   <= appleY_d;
      numTails_q <= numTails_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
    end
  end

  // Body storage is a shift register; segments past num_tails keep stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_TAILS; i++) begin
        tailX_q[i] <= '0;
        tailY_q[i] <= '0;
      end
    end else if (tailShift) begin
      tailX_q[0] <= headX_q;
      tailY_q[0] <= headY_q;
      for (int i = 1; i < MAX_TAILS; i++) begin
        tailX_q[i] <= tailX_q[i-1];
        tailY_q[i] <= tailY_q[i-1];
      end
    end
  end

  assign head_x      = headX_q;
  assign head_y      = headY_q;
  assign apple_x     = appleX_q;
  assign apple_y     = appleY_q;
  assign num_tails   = numTails_q;
  assign tick        = stepNow;
  assign game_over   = (state_q == GAME_OVER);
  assign state       = state_q;
  assign tail_rd_vld = (32'(tail_rd_idx) < 32'(numTails_q));
  assign tail_rd_x   = (32'(tail_rd_idx) < MAX_TAILS) ? tailX_q[tail_rd_idx] : '0;
  assign tail_rd_y   = (32'(tail_rd_idx) < MAX_TAILS) ? tailY_q[tail_rd_idx] : '0;

endmodule

// File: tb/tb_snake_game_core.sv
// tb_snake_game_core
//   Drives two engines (wall mode and wrap mode) on an 8x8 grid with four tail
//   slots and a four-clock step, and compares them against a step-level game
//   model: the body is a queue of cells, the apple comes from an LFSR replica.
`timescale 1ns/1ps
module tb_snake_game_core;

  localparam int GW  = 8;
  localparam int GH  = 8;
  localparam int XW  = 3;
  localparam int YW  = 3;
  localparam int MT  = 4;
  localparam int NTW = 3;
  localparam int TD  = 4;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef SNAKE_SELF_COLLIDE_EN
  localparam bit SELF_COL = 1'b1;
`else
  localparam bit SELF_COL = 1'b0;
`endif

  logic clk, rst_n, start, dirValid, sel;
  logic [1:0] dirIn, rdIdx;
  logic aStart, aDirValid, bStart, bDirValid;

  logic [XW-1:0] aHx, aAx, aTx, bHx, bAx, bTx, curHx, curAx, curTx;
  logic [YW-1:0] aHy, aAy, aTy, bHy, bAy, bTy, curHy, curAy, curTy;
  logic [NTW-1:0] aNum, bNum, curNum;
  logic aTv, bTv, curTv, aTick, bTick, curTick, aGo, bGo, curGo;
  logic [1:0] aSt, bSt, curState;

  assign aStart    = start & ~sel;
  assign bStart    = start & sel;
  assign aDirValid = dirValid & ~sel;
  assign bDirValid = dirValid & sel;

  snake_game_core #(.GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .MAX_TAILS(MT),
                    .NT_W(NTW), .TICK_DIV(TD), .WRAP_MODE(0), .LFSR_SEED(SEED)) dutWall (
    .clk(clk), .rst_n(rst_n), .start(aStart), .dir_in(dirIn), .dir_valid(aDirValid),
    .head_x(aHx), .head_y(aHy), .apple_x(aAx), .apple_y(aAy), .num_tails(aNum),
    .tail_rd_idx(rdIdx), .tail_rd_x(aTx), .tail_rd_y(aTy), .tail_rd_vld(aTv),
    .tick(aTick), .game_over(aGo), .state(aSt));

  snake_game_core #(.GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .MAX_TAILS(MT),
                    .NT_W(NTW), .TICK_DIV(TD), .WRAP_MODE(1), .LFSR_SEED(SEED)) dutWrap (
    .clk(clk), .rst_n(rst_n), .start(bStart), .dir_in(dirIn), .dir_valid(bDirValid),
    .head_x(bHx), .head_y(bHy), .apple_x(bAx), .apple_y(bAy), .num_tails(bNum),
    .tail_rd_idx(rdIdx), .tail_rd_x(bTx), .tail_rd_y(bTy), .tail_rd_vld(bTv),
    .tick(bTick), .game_over(bGo), .state(bSt));

  // Route the selected engine's outputs to the names the tests look at.
  always_comb begin
    curHx = sel ? bHx : aHx;   curHy = sel ? bHy : aHy;
    curAx = sel ? bAx : aAx;   curAy = sel ? bAy : aAy;
    curTx = sel ? bTx : aTx;   curTy = sel ? bTy : aTy;
    curTv = sel ? bTv : aTv;   curNum = sel ? bNum : aNum;
    curTick = sel ? bTick : aTick;
    curGo = sel ? bGo : aGo;   curState = sel ? bSt : aSt;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsrNext(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Replica of the free-running apple LFSR, shared by both engines.
  logic [15:0] mLfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mLfsr <= SEED;
    else        mLfsr <= lfsrNext(mLfsr);
  end

  int checks = 0;
  int errors = 0;
  int mHx, mHy, mAx, mAy, mDir, mPend, mState;
  int bodyX[$];
  int bodyY[$];
  bit lastEat;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Apple search starts in the cycle after v; returns the cell and cycles spent.
  task automatic predictApple(input logic [15:0] v0, output int ax, output int ay, output int wc);
    logic [15:0] v;
    v  = lfsrNext(v0);
    wc = 1;
    while (!((int'(v[2:0]) < GW) && (int'(v[5:3]) < GH)) && wc < 1000) begin
      v = lfsrNext(v);
      wc++;
    end
    ax = int'(v[2:0]);
    ay = int'(v[5:3]);
  endtask

  task automatic finishApple(input logic [15:0] v);
    int ax, ay, wc;
    checks++;
    if (curState !== 2'b10) begin
      errors++;
      $display("[TB] FAIL apple_state: got %b expected 10", curState);
    end
    predictApple(v, ax, ay, wc);
    repeat (wc) nextCycle();
    mState = 1; mAx = ax; mAy = ay;
    checks++;
    if (curState !== 2'b01) begin
      errors++;
      $display("[TB] FAIL run_after_apple: got %b expected 01", curState);
    end
    checks++;
    if (curAx !== XW'(mAx) || curAy !== YW'(mAy)) begin
      errors++;
      $display("[TB] FAIL apple_pos: got (%0d,%0d) expected (%0d,%0d)", curAx, curAy, mAx, mAy);
    end
  endtask

  task automatic doStart();
    logic [15:0] v;
    v = mLfsr;
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    mHx = GW / 2; mHy = GH / 2; mDir = 1; mPend = 1; mState = 2;
    bodyX.delete(); bodyY.delete();
    checks++;
    if (curHx !== XW'(mHx) || curHy !== YW'(mHy) || curNum !== '0 || curGo !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_init: got head (%0d,%0d) num %0d go %b expected (%0d,%0d) 0 0",
               curHx, curHy, curNum, curGo, mHx, mHy);
    end
    finishApple(v);
  endtask

  // One full step period starting at its first cycle, optional direction
  // request at cycle 'offset' and optional (ignored) start pulse at cycle 0.
  task automatic doStep(input bit issue, input int offset, input logic [1:0] d, input bit pulseStart);
    logic [15:0] v;
    int nx, ny, lim;
    bit wall, eat, hit;
    lastEat = 1'b0;
    if (mState != 1) return;
    v = mLfsr;
    for (int i = 0; i < TD; i++) begin
      if (issue && i == offset) begin
        dirValid = 1'b1;
        dirIn    = d;
        if (int'(d) != (mDir ^ 2)) mPend = int'(d);
      end
      if (pulseStart && i == 0) start = 1'b1;
      if (i == 0 || i == TD - 1) begin
        checks++;
        if (curTick !== (i == TD - 1)) begin
          errors++;
          $display("[TB] FAIL tick_cycle%0d: got %b expected %b", i, curTick, (i == TD - 1));
        end
      end
      if (i == TD - 1) v = mLfsr;
      nextCycle();
      dirValid = 1'b0;
      start    = 1'b0;
    end
    mDir = mPend;
    nx = mHx; ny = mHy; wall = 1'b0;
    case (mDir)
      0: ny = mHy - 1;
      1: nx = mHx + 1;
      2: ny = mHy + 1;
      default: nx = mHx - 1;
    endcase
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
      if (sel) begin
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
      end else begin
        wall = 1'b1;
      end
    end
    eat = !wall && nx == mAx && ny == mAy;
    hit = 1'b0;
    if (SELF_COL && !wall) begin
      lim = eat ? bodyX.size() : bodyX.size() - 1;
      for (int k = 0; k < lim; k++)
        if (bodyX[k] == nx && bodyY[k] == ny) hit = 1'b1;
    end
    if (wall || hit) begin
      mState = 3;
    end else begin
      bodyX.push_front(mHx); bodyY.push_front(mHy);
      mHx = nx; mHy = ny;
      if (!eat || bodyX.size() > MT) begin
        void'(bodyX.pop_back()); void'(bodyY.pop_back());
      end
      mState  = eat ? 2 : 1;
      lastEat = eat;
    end
    checks++;
    if (curState !== 2'(mState) || curGo !== (mState == 3)) begin
      errors++;
      $display("[TB] FAIL step_state: got %b go %b expected %0d", curState, curGo, mState);
    end
    checks++;
    if (curHx !== XW'(mHx) || curHy !== YW'(mHy) || curNum !== NTW'(bodyX.size())) begin
      errors++;
      $display("[TB] FAIL step_head: got (%0d,%0d) num %0d expected (%0d,%0d) num %0d",
               curHx, curHy, curNum, mHx, mHy, bodyX.size());
    end
    for (int k = 0; k < MT; k++) begin
      rdIdx = 2'(k);
      #1;
      checks++;
      if (curTv !== (k < bodyX.size())) begin
        errors++;
        $display("[TB] FAIL tail_vld%0d: got %b expected %b", k, curTv, (k < bodyX.size()));
      end
      if (k < bodyX.size()) begin
        checks++;
        if (curTx !== XW'(bodyX[k]) || curTy !== YW'(bodyY[k])) begin
          errors++;
          $display("[TB] FAIL tail%0d: got (%0d,%0d) expected (%0d,%0d)", k, curTx, curTy,
                   bodyX[k], bodyY[k]);
        end
      end
    end
    if (mState == 2) finishApple(v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    nextCycle();
    nextCycle();
    rdIdx = 2'd0;
    #1;
    mState = 0;
    checks++;
    if (curState !== 2'b00 || curGo !== 1'b0 || curTick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b go %b tick %b expected 00 0 0", curState, curGo, curTick);
    end
    checks++;
    if (curHx !== 3'd4 || curHy !== 3'd4 || curAx !== 3'd0 || curAy !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_pos: got head (%0d,%0d) apple (%0d,%0d) expected (4,4) (0,0)",
               curHx, curHy, curAx, curAy);
    end
    checks++;
    if (curNum !== 3'd0 || curTv !== 1'b0 || curTx !== 3'd0 || curTy !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_tails: got num %0d vld %b tail (%0d,%0d) expected 0 0 (0,0)",
               curNum, curTv, curTx, curTy);
    end
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
  endtask

  task automatic test_first_step();
    sel = 1'b0;
    doStart();
    doStep(1'b0, 0, 2'd0, 1'b0);
    checks++;
    if (curHx !== 3'd5 || curHy !== 3'd4) begin
      errors++;
      $display("[TB] FAIL first_step: got (%0d,%0d) expected (5,4)", curHx, curHy);
    end
  endtask

  task automatic test_reversal();
    doStep(1'b1, 0, 2'd3, 1'b1);
    checks++;
    if (curHx !== 3'd6 || curHy !== 3'd4) begin
      errors++;
      $display("[TB] FAIL reversal_drop: got (%0d,%0d) expected (6,4)", curHx, curHy);
    end
    doStep(1'b1, 1, 2'd0, 1'b0);
    checks++;
    if (curHx !== 3'd6 || curHy !== 3'd3) begin
      errors++;
      $display("[TB] FAIL turn_up: got (%0d,%0d) expected (6,3)", curHx, curHy);
    end
  endtask

  task automatic test_wall();
    for (int n = 0; n < 6 && mState != 3; n++) doStep(1'b1, 0, 2'd1, 1'b0);
    checks++;
    if (curGo !== 1'b1 || curState !== 2'b11 || curHx !== 3'd7) begin
      errors++;
      $display("[TB] FAIL wall_over: got go %b state %b x %0d expected 1 11 7", curGo, curState, curHx);
    end
    doStart();
  endtask

  task automatic test_wrap();
    sel = 1'b1;
    doStart();
    repeat (4) doStep(1'b0, 0, 2'd0, 1'b0);
    checks++;
    if (curHx !== 3'd0 || curHy !== 3'd4) begin
      errors++;
      $display("[TB] FAIL wrap_right: got (%0d,%0d) expected (0,4)", curHx, curHy);
    end
    repeat (5) doStep(1'b1, 0, 2'd0, 1'b0);
    checks++;
    if (curHx !== 3'd0 || curHy !== 3'd7 || curGo !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_up: got (%0d,%0d) go %b expected (0,7) 0", curHx, curHy, curGo);
    end
  endtask

  task automatic test_apple();
    int eats;
    logic [1:0] d;
    eats = 0;
    for (int n = 0; n < 400 && eats < 5; n++) begin
      if (mState != 1) begin
        doStart();
        eats = 0;
      end else begin
        if (mAx != mHx) d = (mAx > mHx) ? 2'd1 : 2'd3;
        else            d = (mAy > mHy) ? 2'd2 : 2'd0;
        if (int'(d) == (mDir ^ 2)) d = (mDir == 1 || mDir == 3) ? 2'd0 : 2'd1;
        doStep(1'b1, 0, d, 1'b0);
        if (lastEat) eats++;
      end
    end
    checks++;
    if (eats != 5 || curNum !== 3'd4) begin
      errors++;
      $display("[TB] FAIL apple_growth: got eats %0d num %0d expected 5 4", eats, curNum);
    end
  endtask

  task automatic test_self_collide();
    logic [1:0] seq [4];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0;
    if (mDir == 3) doStep(1'b1, 0, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) doStep(1'b1, 0, seq[k], 1'b0);
    checks++;
    if (curGo !== (mState == 3)) begin
      errors++;
      $display("[TB] FAIL self_loop: got go %b expected %b", curGo, (mState == 3));
    end
  endtask

  task automatic test_random(input logic which);
    sel = which;
    for (int n = 0; n < 80; n++) begin
      if (mState == 0 || mState == 3) doStart();
      else doStep(1'($urandom_range(0, 1)), $urandom_range(0, TD - 2),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic test_mid_reset();
    sel = 1'b1;
    if (mState != 1) doStart();
    doStep(1'b0, 0, 2'd0, 1'b0);
    rst_n = 1'b0;
    rdIdx = 2'd0;
    #1;
    checks++;
    if (curState !== 2'b00 || curHx !== 3'd4 || curHy !== 3'd4 || curNum !== 3'd0 || curTv !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got state %b head (%0d,%0d) num %0d vld %b expected 00 (4,4) 0 0",
               curState, curHx, curHy, curNum, curTv);
    end
    nextCycle();
    rst_n = 1'b1;
    mState = 0;
    bodyX.delete(); bodyY.delete();
    nextCycle();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dirValid = 1'b0; dirIn = 2'd0; rdIdx = 2'd0; sel = 1'b0;
    test_reset();
    test_first_step();
    test_reversal();
    test_wall();
    test_wrap();
    test_apple();
    test_self_collide();
    test_random(1'b1);
    test_mid_reset();
    test_random(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
